// File: rtl/memory_pkg.sv
// Shared constants for the word-addressable memory family.
package memory_pkg;

  localparam logic MODE_RAM  = 1'b0;
  localparam logic MODE_FIFO = 1'b1;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  function automatic logic is_fifo(input logic mode);
    return mode == MODE_FIFO;
  endfunction

endpackage

// File: rtl/memory_nword_if.sv
// Host-side access bus of memory_nword; the tri-state data bus O stays a plain port.
interface memory_nword_if
  import memory_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  I;
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              read;
  logic              write;
  logic              mode;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              err;
  logic              oe;

  modport master (
    output I, address, chipselect, read, write, mode,
    input  full, empty, count, err, oe
  );

  modport slave (
    input  I, address, chipselect, read, write, mode,
    output full, empty, count, err, oe
  );
endinterface

// File: rtl/tristate_buffer_n.sv
// Parametrised tri-state driver: passes d to o when en is set, floats o otherwise.
module tristate_buffer_n #(
  parameter int WIDTH = 8
) (
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output wire  [WIDTH-1:0] o
);

  assign o = en ? d : {WIDTH{1'bz}};

endmodule

// File: rtl/memory_nword.sv
// Word-addressable memory with RAM and FIFO modes, driving a shared tri-state read bus.
module memory_nword
  import memory_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  memory_nword_if.slave   bus,
  output wire [WIDTH-1:0] O
);

  localparam int              ADDR_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              mode_q;
  logic              err_q;
  logic              oe_p1;
  logic [WIDTH-1:0]  rdata_p1;

  logic is_full;
  logic is_empty;
  logic mode_chg;
  logic fifo_acc;
  logic push_ok;
  logic pop_ok;
  logic ovf;
  logic unf;

  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  always_comb begin
    is_full  = (cnt == CNT_FULL);
    is_empty = (cnt == '0);
    mode_chg = (bus.mode != mode_q);
    fifo_acc = bus.chipselect && !mode_chg && is_fifo(mode_q);
    pop_ok   = fifo_acc && bus.read && !is_empty;
    push_ok  = fifo_acc && bus.write && (!is_full || bus.read);
    unf      = fifo_acc && bus.read && is_empty;
    ovf      = fifo_acc && bus.write && is_full && !bus.read;
  end

  // Stage p1: memory update and registered read data / output enable
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      mode_q <= bus.mode;
      oe_p1  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= ovf || unf;
      if (mode_chg) begin
        mode_q <= bus.mode;
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        oe_p1  <= 1'b0;
      end else if (!bus.chipselect) begin
        oe_p1 <= 1'b0;
      end else if (!is_fifo(mode_q)) begin
        // Nonblocking semantics give read-before-write on a shared address.
        oe_p1 <= bus.read;
        if (bus.read)  rdata_p1 <= mem[bus.address];
        if (bus.write) mem[bus.address] <= bus.I;
      end else begin
        oe_p1 <= pop_ok;
        if (pop_ok) begin
          rdata_p1 <= mem[rd_ptr];
          rd_ptr   <= rd_ptr + 1'b1;
        end
        if (push_ok) begin
          mem[wr_ptr] <= bus.I;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (push_ok && !pop_ok)      cnt <= cnt + 1'b1;
        else if (pop_ok && !push_ok) cnt <= cnt - 1'b1;
      end
    end
  end

  assign bus.count = cnt;
  assign bus.full  = is_full;
  assign bus.empty = is_empty;
  assign bus.err   = err_q;
  assign bus.oe    = oe_p1;

  tristate_buffer_n #(.WIDTH(WIDTH)) u_obuf (
    .en (oe_p1),
    .d  (rdata_p1),
    .o  (O)
  );

endmodule
